// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and the rectangle-fill state encoding.
// Used by the fill engine, its coordinate normaliser and the frame buffer itself.
package fb_pkg;

    localparam int H_RES   = 800;
    localparam int V_RES   = 480;
    localparam int COORD_W = 11;

    localparam logic [COORD_W-1:0] H_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] V_MAX = COORD_W'(V_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_e;

endpackage

// File: rtl/fb_coord_norm.sv
// One-axis corner normaliser: orders two coordinates and range-checks them against MAX.
// FB_FILL_CLIP_EN clamps out-of-range values to MAX; otherwise oob_o flags them.
module fb_coord_norm
    import fb_pkg::*;
#(
    parameter logic [COORD_W-1:0] MAX = H_MAX
) (
    input  logic [COORD_W-1:0] a_i,
    input  logic [COORD_W-1:0] b_i,
    output logic [COORD_W-1:0] lo_o,
    output logic [COORD_W-1:0] hi_o,
    output logic               oob_o
);

    logic [COORD_W-1:0] a;
    logic [COORD_W-1:0] b;

`ifdef FB_FILL_CLIP_EN
    assign a     = (a_i > MAX) ? MAX : a_i;
    assign b     = (b_i > MAX) ? MAX : b_i;
    assign oob_o = 1'b0;
`else
    assign a     = a_i;
    assign b     = b_i;
    assign oob_o = (a_i > MAX) || (b_i > MAX);
`endif

    assign lo_o = (a < b) ? a : b;
    assign hi_o = (a < b) ? b : a;

endmodule

// File: rtl/fb_rect_fill.sv
// Filled-rectangle drawing engine: one command per handshake, one frame-buffer write per clock.
// Build option FB_FILL_CLIP_EN: clamp off-screen corners instead of rejecting the command with err.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_SETUP | latched corners normalised and range-checked
// ST_FILL  | one pixel written per cycle in raster order
// ST_DONE  | done (and err if rejected) pulse; next command may be taken
module fb_rect_fill
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    input  logic               cmd_color,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [COORD_W-1:0] fb_pixel_h,
    output logic [COORD_W-1:0] fb_pixel_v,
    output logic               fb_load,
    output logic               fb_in
);

    fill_state_e        state_q, state_d;
    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [COORD_W-1:0] xl_q, xh_q, yh_q;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               color_q;
    logic               err_q;

    logic [COORD_W-1:0] xl, xh, yl, yh;
    logic               oob_x, oob_y;
    logic               accept;

    fb_coord_norm #(.MAX(H_MAX)) u_norm_x (
        .a_i   (x0_q),
        .b_i   (x1_q),
        .lo_o  (xl),
        .hi_o  (xh),
        .oob_o (oob_x)
    );

    fb_coord_norm #(.MAX(V_MAX)) u_norm_y (
        .a_i   (y0_q),
        .b_i   (y1_q),
        .lo_o  (yl),
        .hi_o  (yh),
        .oob_o (oob_y)
    );

    // Ready reopens in the DONE cycle so a held command loses no cycle between fills.
    assign cmd_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept     = cmd_valid && cmd_ready;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign err        = done && err_q;
    assign fb_load    = (state_q == ST_FILL);
    assign fb_pixel_h = x_q;
    assign fb_pixel_v = y_q;
    assign fb_in      = color_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (oob_x || oob_y) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FILL;
                    x_d     = xl;
                    y_d     = yl;
                end
            end
            ST_FILL: begin
                if (x_q == xh_q) begin
                    if (y_q == yh_q) begin
                        state_d = ST_DONE;
                    end else begin
                        x_d = xl_q;
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = cmd_valid ? ST_SETUP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= 1'b0;
            xl_q    <= '0;
            xh_q    <= '0;
            yh_q    <= '0;
            err_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (accept) begin
                x0_q    <= cmd_x0;
                y0_q    <= cmd_y0;
                x1_q    <= cmd_x1;
                y1_q    <= cmd_y1;
                color_q <= cmd_color;
            end
            if (state_q == ST_SETUP) begin
                xl_q  <= xl;
                xh_q  <= xh;
                yh_q  <= yh;
                err_q <= oob_x || oob_y;
            end
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: per-cycle cycle-accurate model plus directed literal cases.
// Honours FB_FILL_CLIP_EN so the same bench covers both build variants.
module tb_fb_rect_fill;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic        cmd_color;
    logic        busy, done, err;
    logic [10:0] fb_pixel_h, fb_pixel_v;
    logic        fb_load, fb_in;

    fb_rect_fill dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_x1     (cmd_x1),
        .cmd_y1     (cmd_y1),
        .cmd_color  (cmd_color),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fb_pixel_h (fb_pixel_h),
        .fb_pixel_v (fb_pixel_v),
        .fb_load    (fb_load),
        .fb_in      (fb_in)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    bit run_chk = 0;
    int wlog[$];

    // model of the command currently in flight: accept cycle, done cycle, geometry
    int m_t = -100, m_d = -100;
    int m_xl, m_yl, m_w, m_n;
    bit m_err, m_c;
    int m_lh = 0, m_lv = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "watchdog");
    end

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: actual %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int enc(input int x, input int y, input int c);
        return x * 4096 + y * 2 + c;
    endfunction

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // per-cycle compare against the model
    int  e_k, ax0, ay0, ax1, ay1;
    bit  e_ld, e_rdy, e_bsy, e_dn;
    always @(negedge clk) begin
        if (run_chk) begin
            e_rdy = (cyc >= m_d);
            e_bsy = (cyc > m_t) && (cyc <= m_d);
            e_dn  = (cyc == m_d);
            e_ld  = (cyc >= m_t + 2) && (cyc <= m_t + 1 + m_n);
            if (e_ld) begin
                e_k  = cyc - m_t - 2;
                m_lh = m_xl + e_k % m_w;
                m_lv = m_yl + e_k / m_w;
            end
            check("cmd_ready", cmd_ready, e_rdy);
            check("busy", busy, e_bsy);
            check("done", done, e_dn);
            check("err", err, e_dn && m_err);
            check("fb_load", fb_load, e_ld);
            check("fb_pixel_h", fb_pixel_h, m_lh);
            check("fb_pixel_v", fb_pixel_v, m_lv);
            if (e_ld) check("fb_in", fb_in, m_c);
            if (fb_load) wlog.push_back(enc(int'(fb_pixel_h), int'(fb_pixel_v), int'(fb_in)));
            if (cmd_valid && e_rdy) begin
                ax0 = int'(cmd_x0); ay0 = int'(cmd_y0);
                ax1 = int'(cmd_x1); ay1 = int'(cmd_y1);
`ifdef FB_FILL_CLIP_EN
                ax0 = clampi(ax0, 799); ax1 = clampi(ax1, 799);
                ay0 = clampi(ay0, 479); ay1 = clampi(ay1, 479);
                m_err = 1'b0;
`else
                m_err = (ax0 >= 800) || (ax1 >= 800) || (ay0 >= 480) || (ay1 >= 480);
`endif
                m_xl = (ax0 < ax1) ? ax0 : ax1;
                m_yl = (ay0 < ay1) ? ay0 : ay1;
                m_w  = ((ax0 < ax1) ? ax1 : ax0) - m_xl + 1;
                m_n  = m_err ? 0 : m_w * (((ay0 < ay1) ? ay1 : ay0) - m_yl + 1);
                m_c  = cmd_color;
                m_t  = cyc;
                m_d  = cyc + 2 + m_n;
            end
        end
    end

    task automatic wait_to(input int c);
        forever begin
            @(negedge clk);
            if (cyc >= c) break;
        end
    endtask

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input bit c, output int t);
        @(posedge clk);
        #1;
        cmd_x0 = 11'(x0); cmd_y0 = 11'(y0);
        cmd_x1 = 11'(x1); cmd_y1 = 11'(y1);
        cmd_color = c;
        cmd_valid = 1'b1;
        t = -1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    int t, ta, tb;
    int exp2[6];
    int xa, xb, ya, yb;
    bit oob;

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
        cmd_color = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_fb_load", fb_load, 0);
        check("rst_pixel_h", fb_pixel_h, 0);
        check("rst_pixel_v", fb_pixel_v, 0);
        check("rst_fb_in", fb_in, 0);
        run_chk = 1'b1;

        // 1x1 rectangle
        send_cmd(0, 0, 0, 0, 1'b1, t);
        wait_to(t + 2);
        check("t1_load", fb_load, 1);
        check("t1_h", fb_pixel_h, 0);
        check("t1_v", fb_pixel_v, 0);
        check("t1_in", fb_in, 1);
        wait_to(t + 3);
        check("t1_done", done, 1);
        check("t1_ready", cmd_ready, 1);

        // reversed corners, raster order
        wlog.delete();
        exp2 = '{enc(3,1,0), enc(4,1,0), enc(5,1,0), enc(3,2,0), enc(4,2,0), enc(5,2,0)};
        send_cmd(5, 2, 3, 1, 1'b0, t);
        wait_to(t + 8);
        check("t2_done", done, 1);
        check("t2_count", wlog.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < wlog.size()) check("t2_pixel", wlog[i], exp2[i]);

        // wide strip touching the right edge
        wlog.delete();
        send_cmd(799, 9, 0, 0, 1'b1, t);
        wait_to(t + 2 + 8000);
        check("t3_done", done, 1);
        check("t3_count", wlog.size(), 8000);
        if (wlog.size() > 0) check("t3_last", wlog[wlog.size()-1], enc(799, 9, 1));

        // off-screen corner
        wlog.delete();
        send_cmd(790, 470, 900, 500, 1'b1, t);
`ifdef FB_FILL_CLIP_EN
        wait_to(t + 102);
        check("t4_done", done, 1);
        check("t4_count", wlog.size(), 100);
        if (wlog.size() > 0) check("t4_last", wlog[wlog.size()-1], enc(799, 479, 1));
`else
        wait_to(t + 2);
        check("t4_done", done, 1);
        check("t4_err", err, 1);
        check("t4_count", wlog.size(), 0);
`endif

        // second command held during a fill
        send_cmd(0, 0, 3, 0, 1'b0, ta);
        send_cmd(10, 10, 11, 10, 1'b1, tb);
        check("t5_accept_cycle", tb, ta + 6);
        wait_to(tb + 2);
        check("t5_load", fb_load, 1);
        check("t5_h", fb_pixel_h, 10);

        // randomized commands, back-to-back or with gaps
        for (int n = 0; n < 40; n++) begin
            oob = ($urandom_range(0, 4) == 0);
            xa = oob ? int'($urandom_range(780, 799)) : int'($urandom_range(0, 799));
            ya = oob ? int'($urandom_range(460, 479)) : int'($urandom_range(0, 479));
            xb = xa + int'($urandom_range(0, 14)) - 7;
            yb = ya + int'($urandom_range(0, 14)) - 7;
            xb = (xb < 0) ? 0 : clampi(xb, 799);
            yb = (yb < 0) ? 0 : clampi(yb, 479);
            if (oob) begin
                case ($urandom_range(0, 3))
                    0: xa = int'($urandom_range(800, 2047));
                    1: xb = int'($urandom_range(800, 2047));
                    2: ya = int'($urandom_range(480, 2047));
                    default: yb = int'($urandom_range(480, 2047));
                endcase
            end
            send_cmd(xa, ya, xb, yb, 1'($urandom_range(0, 1)), t);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_to(m_d + 1);
        check("end_idle_ready", cmd_ready, 1);

        // reset in the middle of a fill
        send_cmd(0, 0, 9, 9, 1'b1, t);
        wait_to(t + 22);
        check("t6_filling", fb_load, 1);
        run_chk = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_load_drop", fb_load, 0);
        check("t6_ready", cmd_ready, 1);
        check("t6_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_no_done", done, 0);
            check("t6_load_low", fb_load, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_after_done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
